rtc_tick_cnt: RTL and testbench



---
 rtl/rtc_tick_cnt.sv | 131 +++++++++++++
 tb/tb_rtc_tick_cnt.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_tick_cnt.sv
// Receive side of the RTC divided clock: synchronize, edge-detect, count ticks, raise match IRQ.
// Optional sticky wrap interrupt (wrap_clr / wrap_int) when RTC_TICK_CNT_WRAP_IRQ_EN is defined.
//
// state | meaning
// IDLE  | counting disabled, edges discarded
// ARM   | flushing synchronizer history for SYNC_STAGES+1 cycles, edges discarded
// RUN   | each accepted rising edge increments the counter
module rtc_tick_cnt #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             rtc_clk_in,
  input  logic             cnt_en,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] match_val,
  input  logic             int_mask,
  input  logic             int_clr,
`ifdef RTC_TICK_CNT_WRAP_IRQ_EN
  input  logic             wrap_clr,
  output logic             wrap_int,
`endif
  output logic [CNT_W-1:0] cnt_val,
  output logic             tick_pulse,
  output logic             raw_int,
  output logic             match_int
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [2:0] ARM_LOAD = 3'(SYNC_STAGES + 1);

  state_t                 state_q, state_d;
  logic [2:0]             arm_q, arm_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  logic                   raw_q, raw_d;
  logic                   sync_out;
  logic                   edge_det;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_out & ~prev_q;

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= ST_IDLE;
      arm_q   <= '0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      raw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      raw_q   <= raw_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rtc_clk_in};
    prev_d  = sync_out;
    state_d = state_q;
    arm_d   = arm_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_en) begin
          state_d = ST_ARM;
          arm_d   = ARM_LOAD;
        end
      end
      ST_ARM: begin
        if (!cnt_en) begin
          state_d = ST_IDLE;
        end else if (arm_q <= 3'd1) begin
          state_d = ST_RUN;
          arm_d   = '0;
        end else begin
          arm_d = arm_q - 3'd1;
        end
      end
      ST_RUN: begin
        // Dropping cnt_en takes effect this cycle, so a coincident edge is lost.
        if (!cnt_en) state_d = ST_IDLE;
        else         tick_d  = edge_det;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_d = cnt_q;
    if (load_en)     cnt_d = load_val;
    else if (tick_d) cnt_d = cnt_q + CNT_W'(1);

    raw_d = ((load_en | tick_d) & (cnt_d == match_val)) | (raw_q & ~int_clr);
  end

`ifdef RTC_TICK_CNT_WRAP_IRQ_EN
  logic wrap_q, wrap_d;

  always_comb begin
    // A coincident load wins over the tick, so it can never count as a wrap.
    wrap_d = (tick_d & ~load_en & (&cnt_q)) | (wrap_q & ~wrap_clr);
  end

  always_ff @(posedge pclk) begin
    if (prst) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  end

  assign wrap_int = wrap_q;
`endif

  assign cnt_val    = cnt_q;
  assign tick_pulse = tick_q;
  assign raw_int    = raw_q;
  assign match_int  = raw_q & ~int_mask;

endmodule

// File: tb/tb_rtc_tick_cnt.sv
// Directed bench for rtc_tick_cnt: per-cycle vector table plus hand sequences for ARM, wrap and reset.
module tb_rtc_tick_cnt;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        rtc_clk_in = 1'b0;
  logic        cnt_en = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_val = '0;
  logic [31:0] match_val = '0;
  logic        int_mask = 1'b0;
  logic        int_clr = 1'b0;
  logic [31:0] cnt_val;
  logic        tick_pulse;
  logic        raw_int;
  logic        match_int;
`ifdef RTC_TICK_CNT_WRAP_IRQ_EN
  logic        wrap_clr = 1'b0;
  logic        wrap_int;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  rtc_tick_cnt #(.SYNC_STAGES(2), .CNT_W(32)) dut (
    .pclk       (pclk),
    .prst       (prst),
    .rtc_clk_in (rtc_clk_in),
    .cnt_en     (cnt_en),
    .load_en    (load_en),
    .load_val   (load_val),
    .match_val  (match_val),
    .int_mask   (int_mask),
    .int_clr    (int_clr),
`ifdef RTC_TICK_CNT_WRAP_IRQ_EN
    .wrap_clr   (wrap_clr),
    .wrap_int   (wrap_int),
`endif
    .cnt_val    (cnt_val),
    .tick_pulse (tick_pulse),
    .raw_int    (raw_int),
    .match_int  (match_int)
  );

  typedef struct {
    logic        rtc;
    logic        en;
    logic        ld;
    logic [31:0] ld_val;
    logic [31:0] m_val;
    logic        mask;
    logic        clr;
    logic [31:0] e_cnt;
    logic        e_tick;
    logic        e_raw;
    logic        e_mint;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic rtc, input logic en, input logic ld,
                              input logic [31:0] ld_val, input logic [31:0] m_val,
                              input logic mask, input logic clr, input logic [31:0] e_cnt,
                              input logic e_tick, input logic e_raw, input logic e_mint);
    vec_t v;
    v.rtc = rtc; v.en = en; v.ld = ld; v.ld_val = ld_val; v.m_val = m_val;
    v.mask = mask; v.clr = clr; v.e_cnt = e_cnt; v.e_tick = e_tick;
    v.e_raw = e_raw; v.e_mint = e_mint;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clk();
    @(posedge pclk);
    #1;
  endtask

  task automatic clks(input int n);
    for (int i = 0; i < n; i++) clk();
  endtask

  initial begin
    int ticks;
    logic exp_tick;

    tbl[0]  = mk(1, 0, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[10] = mk(1, 1, 0, 0,     'hA, 0, 0, 0,   0, 0, 0);
    tbl[11] = mk(1, 1, 0, 0,     'hA, 0, 0, 1,   1, 0, 0);
    tbl[12] = mk(1, 1, 0, 0,     'hA, 0, 0, 1,   0, 0, 0);
    tbl[13] = mk(0, 1, 1, 'h9,   'hA, 0, 0, 'h9, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0,     'hA, 0, 0, 'h9, 0, 0, 0);
    tbl[15] = mk(1, 1, 0, 0,     'hA, 0, 0, 'h9, 0, 0, 0);
    tbl[16] = mk(1, 1, 0, 0,     'hA, 0, 0, 'h9, 0, 0, 0);
    tbl[17] = mk(1, 1, 0, 0,     'hA, 0, 0, 'hA, 1, 1, 1);
    tbl[18] = mk(1, 1, 0, 0,     'hA, 1, 0, 'hA, 0, 1, 0);
    tbl[19] = mk(1, 1, 0, 0,     'hA, 1, 1, 'hA, 0, 0, 0);
    tbl[20] = mk(1, 1, 0, 0,     'hA, 0, 0, 'hA, 0, 0, 0);
    tbl[21] = mk(1, 1, 0, 0,     'h3, 0, 0, 'hA, 0, 0, 0);
    tbl[22] = mk(1, 1, 0, 0,     'hA, 0, 0, 'hA, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0,     'hA, 0, 0, 'hA, 0, 0, 0);

    // Reset state
    clks(2);
    chk("rst_cnt",  cnt_val,    32'h0);
    chk("rst_tick", tick_pulse, 32'h0);
    chk("rst_raw",  raw_int,    32'h0);
    chk("rst_mint", match_int,  32'h0);
    prst = 1'b0;

    // Vector table: level high at enable, first edge, load to match, mask and clear
    for (int i = 0; i < 24; i++) begin
      rtc_clk_in = tbl[i].rtc;
      cnt_en     = tbl[i].en;
      load_en    = tbl[i].ld;
      load_val   = tbl[i].ld_val;
      match_val  = tbl[i].m_val;
      int_mask   = tbl[i].mask;
      int_clr    = tbl[i].clr;
      clk();
      chk($sformatf("vec%0d_cnt", i),  cnt_val,    tbl[i].e_cnt);
      chk($sformatf("vec%0d_tick", i), tick_pulse, 32'(tbl[i].e_tick));
      chk($sformatf("vec%0d_raw", i),  raw_int,    32'(tbl[i].e_raw));
      chk($sformatf("vec%0d_mint", i), match_int,  32'(tbl[i].e_mint));
    end
    load_en = 1'b0; int_clr = 1'b0; int_mask = 1'b0;

    // Free-running toggle every 8 pclk after a fresh reset: ticks at cycles 10, 26, 42, ...
    prst = 1'b1; cnt_en = 1'b0; rtc_clk_in = 1'b0;
    clks(2);
    prst = 1'b0;
    ticks = 0;
    for (int c = 0; c < 96; c++) begin
      cnt_en     = 1'b1;
      rtc_clk_in = ((c / 8) % 2) == 1;
      clk();
      exp_tick = (c % 16) == 10;
      if (exp_tick) ticks++;
      chk($sformatf("run%0d_tick", c), tick_pulse, 32'(exp_tick));
      chk($sformatf("run%0d_cnt", c),  cnt_val,    32'(ticks));
    end

    // Load coincident with a tick: load wins, pulse still shows
    rtc_clk_in = 1'b0; clks(3);
    rtc_clk_in = 1'b1; clks(2);
    load_en = 1'b1; load_val = 32'h55;
    clk();
    load_en = 1'b0;
    chk("ldtick_cnt",  cnt_val,    32'h55);
    chk("ldtick_tick", tick_pulse, 32'h1);
    chk("ldtick_raw",  raw_int,    32'h0);
    clk();
    chk("ldtick_tick_off", tick_pulse, 32'h0);
    chk("ldtick_hold",     cnt_val,    32'h55);

    // Clear coincident with a matching tick: set wins
    match_val = 32'h56;
    rtc_clk_in = 1'b0; clks(3);
    rtc_clk_in = 1'b1; clks(2);
    int_clr = 1'b1;
    clk();
    int_clr = 1'b0;
    chk("setclr_cnt", cnt_val, 32'h56);
    chk("setclr_raw", raw_int, 32'h1);
    int_clr = 1'b1;
    clk();
    int_clr = 1'b0;
    chk("clr_raw", raw_int, 32'h0);

    // Wrap from all-ones on a tick
    rtc_clk_in = 1'b0; clks(3);
    load_en = 1'b1; load_val = 32'hFFFF_FFFF;
    clk();
    load_en = 1'b0;
    chk("wrap_pre", cnt_val, 32'hFFFF_FFFF);
    rtc_clk_in = 1'b1; clks(3);
    chk("wrap_cnt",  cnt_val,    32'h0);
    chk("wrap_tick", tick_pulse, 32'h1);
`ifdef RTC_TICK_CNT_WRAP_IRQ_EN
    chk("wrap_int_set", wrap_int, 32'h1);
    wrap_clr = 1'b1;
    clk();
    wrap_clr = 1'b0;
    chk("wrap_int_clr", wrap_int, 32'h0);
    load_en = 1'b1; load_val = 32'hFFFF_FFFF;
    clk();
    load_val = 32'h0;
    clk();
    load_en = 1'b0;
    chk("wrap_load_cnt", cnt_val,  32'h0);
    chk("wrap_load_int", wrap_int, 32'h0);
`endif

    // Reset mid-count with the flag set, then ARM must be repeated
    rtc_clk_in = 1'b0;
    load_en = 1'b1; load_val = 32'h1234; match_val = 32'h1234;
    clk();
    load_en = 1'b0;
    chk("pre_rst_cnt", cnt_val, 32'h1234);
    chk("pre_rst_raw", raw_int, 32'h1);
    int_mask = 1'b1; #1;
    chk("mask_mint", match_int, 32'h0);
    int_mask = 1'b0; #1;
    chk("unmask_mint", match_int, 32'h1);
    prst = 1'b1;
    clk();
    chk("midrst_cnt",  cnt_val,   32'h0);
    chk("midrst_raw",  raw_int,   32'h0);
    chk("midrst_mint", match_int, 32'h0);
`ifdef RTC_TICK_CNT_WRAP_IRQ_EN
    chk("midrst_wrap", wrap_int, 32'h0);
`endif
    prst = 1'b0;
    rtc_clk_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      clk();
      chk($sformatf("rearm%0d_tick", c), tick_pulse, 32'h0);
      chk($sformatf("rearm%0d_cnt", c),  cnt_val,    32'h0);
    end
    rtc_clk_in = 1'b0; clks(3);
    rtc_clk_in = 1'b1; clks(3);
    chk("rearm_first_cnt",  cnt_val,    32'h1);
    chk("rearm_first_tick", tick_pulse, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
